// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types for the ibex instruction/data bus arbiter
package ibex_pkg;

    typedef enum logic {
        BusHostInstr = 1'b0,
        BusHostData  = 1'b1
    } bus_host_e;

    typedef enum logic {
        LockIdle   = 1'b0,
        LockLocked = 1'b1
    } bus_lock_e;

    localparam int unsigned BusMaxOutstandingMax = 4;

    function automatic bus_host_e bus_host_other(input bus_host_e host);
        return (host == BusHostInstr) ? BusHostData : BusHostInstr;
    endfunction

endpackage

// File: rtl/ibex_bus_arbiter_owner_fifo.sv
// rtl/ibex_bus_arbiter_owner_fifo.sv - in-order FIFO of host ids for granted, unanswered transactions
module ibex_bus_arbiter_owner_fifo
    import ibex_pkg::*;
#(
    parameter  int unsigned Depth = 2,
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  bus_host_e push_host_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output bus_host_e head_o
);

    bus_host_e       r_mem [Depth];
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [CntW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign w_full  = (r_count == CntW'(Depth));
    assign w_empty = (r_count == '0);
    // A pop frees the slot a same-cycle push needs, so push is legal when full if popping.
    assign w_pop   = pop_i & ~w_empty;
    assign w_push  = push_i & (~w_full | w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_host_i;
        end
    end

    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign head_o  = r_mem[r_rd_ptr];

endmodule

// File: rtl/ibex_bus_arbiter.sv
// rtl/ibex_bus_arbiter.sv - shares one req/gnt/rvalid device port between ibex instr and data hosts
module ibex_bus_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          DataPriority   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic [6:0]  instr_rdata_intg_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [6:0]  data_wdata_intg_i,
    output logic [31:0] data_rdata_o,
    output logic [6:0]  data_rdata_intg_o,
    output logic        data_err_o,

    output logic        dev_req_o,
    output logic        dev_we_o,
    output logic [3:0]  dev_be_o,
    output logic [31:0] dev_addr_o,
    output logic [31:0] dev_wdata_o,
    output logic [6:0]  dev_wdata_intg_o,
    input  logic        dev_gnt_i,
    input  logic        dev_rvalid_i,
    input  logic        dev_err_i,
    input  logic [31:0] dev_rdata_i,
    input  logic [6:0]  dev_rdata_intg_i,

    output logic        resp_unexpected_o
);

    bus_lock_e r_lock_state;
    bus_lock_e w_lock_state_next;
    bus_host_e r_lock_owner;
    bus_host_e w_lock_owner_next;
    // Host that wins a round-robin tie next; it is always the one not granted last.
    bus_host_e r_rr_prio;
    logic      r_resp_unexpected;

    bus_host_e w_sel;
    bus_host_e w_head;
    logic      w_req_sel;
    logic      w_fifo_full;
    logic      w_fifo_empty;
    logic      w_pop;
    logic      w_dev_req;
    logic      w_grant;

    always_comb begin
        w_sel = r_rr_prio;
        if (r_lock_state == LockLocked) begin
            w_sel = r_lock_owner;
        end else if (instr_req_i && !data_req_i) begin
            w_sel = BusHostInstr;
        end else if (data_req_i && !instr_req_i) begin
            w_sel = BusHostData;
        end else if (instr_req_i && data_req_i) begin
            w_sel = DataPriority ? BusHostData : r_rr_prio;
        end
    end

    assign w_req_sel = (w_sel == BusHostData) ? data_req_i : instr_req_i;
    assign w_pop     = dev_rvalid_i & ~w_fifo_empty;
    // A response retiring this cycle frees a slot, so a full FIFO can still accept a grant.
    assign w_dev_req = w_req_sel & (~w_fifo_full | w_pop) & ~rst_i;
    assign w_grant   = w_dev_req & dev_gnt_i;

    always_comb begin
        w_lock_state_next = r_lock_state;
        w_lock_owner_next = r_lock_owner;
        case (r_lock_state)
            LockIdle: begin
                if (w_dev_req && !dev_gnt_i) begin
                    w_lock_state_next = LockLocked;
                    w_lock_owner_next = w_sel;
                end
            end
            LockLocked: begin
                if (w_grant) begin
                    w_lock_state_next = LockIdle;
                end
            end
            default: begin
                w_lock_state_next = LockIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock_state <= LockIdle;
            r_lock_owner <= BusHostInstr;
        end else begin
            r_lock_state <= w_lock_state_next;
            r_lock_owner <= w_lock_owner_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_prio         <= BusHostInstr;
            r_resp_unexpected <= 1'b0;
        end else begin
            if (w_grant) begin
                r_rr_prio <= bus_host_other(w_sel);
            end
            if (dev_rvalid_i && w_fifo_empty) begin
                r_resp_unexpected <= 1'b1;
            end
        end
    end

    ibex_bus_arbiter_owner_fifo #(
        .Depth (MaxOutstanding)
    ) u_owner_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_grant),
        .push_host_i (w_sel),
        .pop_i       (dev_rvalid_i),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .head_o      (w_head)
    );

    always_comb begin
        dev_we_o         = 1'b0;
        dev_be_o         = 4'hF;
        dev_addr_o       = instr_addr_i;
        dev_wdata_o      = 32'h0;
        dev_wdata_intg_o = 7'h0;
        if (w_sel == BusHostData) begin
            dev_we_o         = data_we_i;
            dev_be_o         = data_be_i;
            dev_addr_o       = data_addr_i;
            dev_wdata_o      = data_wdata_i;
            dev_wdata_intg_o = data_wdata_intg_i;
        end
    end

    assign dev_req_o      = w_dev_req;
    assign instr_gnt_o    = w_grant & (w_sel == BusHostInstr);
    assign data_gnt_o     = w_grant & (w_sel == BusHostData);
    assign instr_rvalid_o = w_pop & (w_head == BusHostInstr) & ~rst_i;
    assign data_rvalid_o  = w_pop & (w_head == BusHostData) & ~rst_i;

    assign instr_rdata_o      = dev_rdata_i;
    assign instr_rdata_intg_o = dev_rdata_intg_i;
    assign instr_err_o        = dev_err_i;
    assign data_rdata_o       = dev_rdata_i;
    assign data_rdata_intg_o  = dev_rdata_intg_i;
    assign data_err_o         = dev_err_i;

    assign resp_unexpected_o = r_resp_unexpected;

endmodule

// File: tb/tb_ibex_bus_arbiter.sv
// tb/tb_ibex_bus_arbiter.sv - directed self-checking bench for ibex_bus_arbiter
module tb_ibex_bus_arbiter;

    localparam logic [31:0] IADDR  = 32'h0000_1000;
    localparam logic [31:0] DADDR  = 32'h8000_0040;
    localparam logic [31:0] DWDATA = 32'hCAFE_F00D;
    localparam logic [6:0]  DINTG  = 7'h55;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [6:0]  data_wdata_intg;
    logic        dev_gnt;
    logic        dev_rvalid;
    logic        dev_err;
    logic [31:0] dev_rdata;
    logic [6:0]  dev_rdata_intg;

    logic        a_instr_gnt, a_instr_rvalid, a_instr_err;
    logic [31:0] a_instr_rdata;
    logic [6:0]  a_instr_rdata_intg;
    logic        a_data_gnt, a_data_rvalid, a_data_err;
    logic [31:0] a_data_rdata;
    logic [6:0]  a_data_rdata_intg;
    logic        a_dev_req, a_dev_we, a_resp_unexp;
    logic [3:0]  a_dev_be;
    logic [31:0] a_dev_addr, a_dev_wdata;
    logic [6:0]  a_dev_wdata_intg;

    logic        b_instr_gnt, b_instr_rvalid, b_instr_err;
    logic [31:0] b_instr_rdata;
    logic [6:0]  b_instr_rdata_intg;
    logic        b_data_gnt, b_data_rvalid, b_data_err;
    logic [31:0] b_data_rdata;
    logic [6:0]  b_data_rdata_intg;
    logic        b_dev_req, b_dev_we, b_resp_unexp;
    logic [3:0]  b_dev_be;
    logic [31:0] b_dev_addr, b_dev_wdata;
    logic [6:0]  b_dev_wdata_intg;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ibex_bus_arbiter #(.MaxOutstanding(2), .DataPriority(1'b1)) u_dut_fp (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_gnt_o(a_instr_gnt), .instr_rvalid_o(a_instr_rvalid),
        .instr_addr_i(instr_addr), .instr_rdata_o(a_instr_rdata),
        .instr_rdata_intg_o(a_instr_rdata_intg), .instr_err_o(a_instr_err),
        .data_req_i(data_req), .data_gnt_o(a_data_gnt), .data_rvalid_o(a_data_rvalid),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_wdata_intg_i(data_wdata_intg),
        .data_rdata_o(a_data_rdata), .data_rdata_intg_o(a_data_rdata_intg), .data_err_o(a_data_err),
        .dev_req_o(a_dev_req), .dev_we_o(a_dev_we), .dev_be_o(a_dev_be), .dev_addr_o(a_dev_addr),
        .dev_wdata_o(a_dev_wdata), .dev_wdata_intg_o(a_dev_wdata_intg),
        .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid), .dev_err_i(dev_err),
        .dev_rdata_i(dev_rdata), .dev_rdata_intg_i(dev_rdata_intg),
        .resp_unexpected_o(a_resp_unexp)
    );

    ibex_bus_arbiter #(.MaxOutstanding(2), .DataPriority(1'b0)) u_dut_rr (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_gnt_o(b_instr_gnt), .instr_rvalid_o(b_instr_rvalid),
        .instr_addr_i(instr_addr), .instr_rdata_o(b_instr_rdata),
        .instr_rdata_intg_o(b_instr_rdata_intg), .instr_err_o(b_instr_err),
        .data_req_i(data_req), .data_gnt_o(b_data_gnt), .data_rvalid_o(b_data_rvalid),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_wdata_intg_i(data_wdata_intg),
        .data_rdata_o(b_data_rdata), .data_rdata_intg_o(b_data_rdata_intg), .data_err_o(b_data_err),
        .dev_req_o(b_dev_req), .dev_we_o(b_dev_we), .dev_be_o(b_dev_be), .dev_addr_o(b_dev_addr),
        .dev_wdata_o(b_dev_wdata), .dev_wdata_intg_o(b_dev_wdata_intg),
        .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid), .dev_err_i(dev_err),
        .dev_rdata_i(dev_rdata), .dev_rdata_intg_i(dev_rdata_intg),
        .resp_unexpected_o(b_resp_unexp)
    );

    task automatic idle_inputs();
        instr_req = 1'b0; data_req = 1'b0; dev_gnt = 1'b0; dev_rvalid = 1'b0;
        dev_err = 1'b0; dev_rdata = 32'h0; dev_rdata_intg = 7'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        instr_req = 1'b1; data_req = 1'b1; dev_gnt = 1'b1; dev_rvalid = 1'b1;
        @(negedge clk);
        n_checks++; if (a_dev_req !== 1'b0) begin n_errors++; $display("FAIL rst_dev_req: got %b want 0", a_dev_req); end
        n_checks++; if ({a_instr_gnt, a_data_gnt} !== 2'b00) begin n_errors++; $display("FAIL rst_gnt: got %b want 00", {a_instr_gnt, a_data_gnt}); end
        n_checks++; if ({a_instr_rvalid, a_data_rvalid} !== 2'b00) begin n_errors++; $display("FAIL rst_rvalid: got %b want 00", {a_instr_rvalid, a_data_rvalid}); end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_checks++; if (a_resp_unexp !== 1'b0) begin n_errors++; $display("FAIL rst_unexpected: got %b want 0", a_resp_unexp); end
        next_cycle();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        instr_req = 1'b1; data_req = 1'b1; dev_gnt = 1'b1;
        @(negedge clk);
        n_checks++; if ({a_instr_gnt, a_data_gnt} !== 2'b01) begin n_errors++; $display("FAIL fp_first_gnt: got i/d=%b want 01", {a_instr_gnt, a_data_gnt}); end
        n_checks++; if (a_dev_addr !== DADDR) begin n_errors++; $display("FAIL fp_first_addr: got %h want %h", a_dev_addr, DADDR); end
        n_checks++; if (a_dev_wdata !== DWDATA || a_dev_wdata_intg !== DINTG) begin n_errors++; $display("FAIL fp_payload: got %h/%h want %h/%h", a_dev_wdata, a_dev_wdata_intg, DWDATA, DINTG); end
        next_cycle();
        data_req = 1'b0;
        @(negedge clk);
        n_checks++; if ({a_instr_gnt, a_data_gnt} !== 2'b10) begin n_errors++; $display("FAIL fp_second_gnt: got i/d=%b want 10", {a_instr_gnt, a_data_gnt}); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt [4];
        exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
        do_reset();
        instr_req = 1'b1; data_req = 1'b1; dev_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dev_rvalid = (i > 0);
            @(negedge clk);
            n_checks++; if ({b_instr_gnt, b_data_gnt} !== exp_gnt[i]) begin n_errors++; $display("FAIL rr_gnt[%0d]: got i/d=%b want %b", i, {b_instr_gnt, b_data_gnt}, exp_gnt[i]); end
            if (i == 1) begin
                n_checks++; if ({b_instr_rvalid, b_data_rvalid} !== 2'b10) begin n_errors++; $display("FAIL rr_rvalid: got i/d=%b want 10", {b_instr_rvalid, b_data_rvalid}); end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        instr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_req = (i >= 1);
            @(negedge clk);
            n_checks++; if (a_dev_addr !== IADDR) begin n_errors++; $display("FAIL lock_addr[%0d]: got %h want %h", i, a_dev_addr, IADDR); end
            n_checks++; if (a_dev_req !== 1'b1 || a_data_gnt !== 1'b0) begin n_errors++; $display("FAIL lock_req[%0d]: got req=%b dgnt=%b want 1/0", i, a_dev_req, a_data_gnt); end
            next_cycle();
        end
        dev_gnt = 1'b1;
        @(negedge clk);
        n_checks++; if ({a_instr_gnt, a_data_gnt} !== 2'b10) begin n_errors++; $display("FAIL lock_release_gnt: got i/d=%b want 10", {a_instr_gnt, a_data_gnt}); end
        n_checks++; if (a_dev_we !== 1'b0 || a_dev_be !== 4'hF || a_dev_wdata !== 32'h0) begin n_errors++; $display("FAIL lock_instr_payload: got we=%b be=%h wd=%h want 0/f/0", a_dev_we, a_dev_be, a_dev_wdata); end
        next_cycle();
        instr_req = 1'b0;
        @(negedge clk);
        n_checks++; if ({a_instr_gnt, a_data_gnt} !== 2'b01) begin n_errors++; $display("FAIL lock_data_gnt: got i/d=%b want 01", {a_instr_gnt, a_data_gnt}); end
        n_checks++; if (a_dev_we !== 1'b1 || a_dev_be !== 4'h3) begin n_errors++; $display("FAIL lock_data_payload: got we=%b be=%h want 1/3", a_dev_we, a_dev_be); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_full();
        do_reset();
        instr_req = 1'b1; dev_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (a_instr_gnt !== 1'b1) begin n_errors++; $display("FAIL full_fill_gnt[%0d]: got %b want 1", i, a_instr_gnt); end
            next_cycle();
        end
        @(negedge clk);
        n_checks++; if (a_dev_req !== 1'b0 || a_instr_gnt !== 1'b0) begin n_errors++; $display("FAIL full_blocked: got req=%b gnt=%b want 0/0", a_dev_req, a_instr_gnt); end
        next_cycle();
        dev_gnt = 1'b0; dev_rvalid = 1'b1; dev_rdata = 32'h1111_2222;
        @(negedge clk);
        n_checks++; if ({a_instr_rvalid, a_data_rvalid} !== 2'b10) begin n_errors++; $display("FAIL full_pop_rvalid: got i/d=%b want 10", {a_instr_rvalid, a_data_rvalid}); end
        n_checks++; if (a_dev_req !== 1'b1) begin n_errors++; $display("FAIL full_pop_req: got %b want 1", a_dev_req); end
        n_checks++; if (a_instr_rdata !== 32'h1111_2222) begin n_errors++; $display("FAIL full_rdata: got %h want 11112222", a_instr_rdata); end
        next_cycle();
        dev_gnt = 1'b1;
        @(negedge clk);
        n_checks++; if (a_instr_rvalid !== 1'b1 || a_instr_gnt !== 1'b1) begin n_errors++; $display("FAIL full_push_pop: got rv=%b gnt=%b want 1/1", a_instr_rvalid, a_instr_gnt); end
        next_cycle();
        instr_req = 1'b0; dev_gnt = 1'b0;
        @(negedge clk);
        n_checks++; if (a_instr_rvalid !== 1'b1) begin n_errors++; $display("FAIL full_last_rvalid: got %b want 1", a_instr_rvalid); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        instr_req = 1'b1; dev_gnt = 1'b1;
        next_cycle();
        instr_req = 1'b0; data_req = 1'b1; dev_rvalid = 1'b1;
        @(negedge clk);
        n_checks++; if (a_data_gnt !== 1'b1) begin n_errors++; $display("FAIL b2b_data_gnt: got %b want 1", a_data_gnt); end
        n_checks++; if ({a_instr_rvalid, a_data_rvalid} !== 2'b10) begin n_errors++; $display("FAIL b2b_first_rvalid: got i/d=%b want 10", {a_instr_rvalid, a_data_rvalid}); end
        next_cycle();
        data_req = 1'b0; dev_gnt = 1'b0;
        dev_rdata = 32'hDEAD_BEEF; dev_rdata_intg = 7'h2A; dev_err = 1'b1;
        @(negedge clk);
        n_checks++; if ({a_instr_rvalid, a_data_rvalid} !== 2'b01) begin n_errors++; $display("FAIL b2b_second_rvalid: got i/d=%b want 01", {a_instr_rvalid, a_data_rvalid}); end
        n_checks++; if (a_data_rdata !== 32'hDEAD_BEEF || a_data_rdata_intg !== 7'h2A || a_data_err !== 1'b1) begin n_errors++; $display("FAIL b2b_data_resp: got %h/%h/%b want deadbeef/2a/1", a_data_rdata, a_data_rdata_intg, a_data_err); end
        n_checks++; if (a_instr_rdata !== 32'hDEAD_BEEF || a_instr_err !== 1'b1) begin n_errors++; $display("FAIL b2b_broadcast: got %h/%b want deadbeef/1", a_instr_rdata, a_instr_err); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_unexpected();
        do_reset();
        dev_rvalid = 1'b1;
        @(negedge clk);
        n_checks++; if ({a_instr_rvalid, a_data_rvalid} !== 2'b00) begin n_errors++; $display("FAIL unexp_no_rvalid: got i/d=%b want 00", {a_instr_rvalid, a_data_rvalid}); end
        n_checks++; if (a_resp_unexp !== 1'b0) begin n_errors++; $display("FAIL unexp_same_cycle: got %b want 0", a_resp_unexp); end
        next_cycle();
        dev_rvalid = 1'b0;
        @(negedge clk);
        n_checks++; if (a_resp_unexp !== 1'b1) begin n_errors++; $display("FAIL unexp_set: got %b want 1", a_resp_unexp); end
        next_cycle();
        instr_req = 1'b1; dev_gnt = 1'b1;
        @(negedge clk);
        n_checks++; if (a_instr_gnt !== 1'b1) begin n_errors++; $display("FAIL unexp_after_gnt: got %b want 1", a_instr_gnt); end
        next_cycle();
        instr_req = 1'b0; dev_gnt = 1'b0; dev_rvalid = 1'b1;
        @(negedge clk);
        n_checks++; if (a_instr_rvalid !== 1'b1 || a_resp_unexp !== 1'b1) begin n_errors++; $display("FAIL unexp_sticky_rvalid: got rv=%b flag=%b want 1/1", a_instr_rvalid, a_resp_unexp); end
        next_cycle();
        do_reset();
        @(negedge clk);
        n_checks++; if (a_resp_unexp !== 1'b0) begin n_errors++; $display("FAIL unexp_cleared: got %b want 0", a_resp_unexp); end
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        instr_addr = IADDR; data_addr = DADDR; data_we = 1'b1; data_be = 4'h3;
        data_wdata = DWDATA; data_wdata_intg = DINTG;
        idle_inputs();
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_lock();
        test_full();
        test_back_to_back();
        test_unexpected();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1);
    end

endmodule
